// File: rtl/buzzer_sequencer.sv
// buzzer_sequencer: turns one-cycle event requests into timed tone-code sequences.
// Patterns: click, double click, alarm, three-note melody. Durations are counted in Tick pulses.
// Build option: define ALARM_REPEAT_EN to make the alarm loop (tone, gap, tone, ...) until
// acknowledged or preempted; left undefined, the alarm plays once and pulses Done.
module buzzer_sequencer #(
    parameter int unsigned SHORT_T = 100,
    parameter int unsigned GAP_T   = 100,
    parameter int unsigned LONG_T  = 1000,
    parameter int unsigned NOTE_T  = 200,
    parameter int unsigned CW      = 10
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick,
    input  logic       Req,
    input  logic [1:0] ReqType,
    input  logic       Ack,
    output logic [1:0] Bu,
    output logic       Busy,
    output logic       Done,
    output logic       Drop
);

    typedef enum logic [1:0] {StIdle, StTone, StGap} state_e;

    localparam logic [1:0] TypeClick  = 2'b00;
    localparam logic [1:0] TypeDouble = 2'b01;
    localparam logic [1:0] TypeAlarm  = 2'b10;
    localparam logic [1:0] TypeMelody = 2'b11;

    localparam logic [CW-1:0] LpShort = CW'(SHORT_T);
    localparam logic [CW-1:0] LpGap   = CW'(GAP_T);
    localparam logic [CW-1:0] LpLong  = CW'(LONG_T);
    localparam logic [CW-1:0] LpNote  = CW'(NOTE_T);
    localparam logic [CW-1:0] LpOne   = CW'(1);

    state_e        r_state,    w_state_d;
    logic [1:0]    r_cur_type, w_cur_type_d;
    logic [1:0]    r_step,     w_step_d;
    logic [CW-1:0] r_cnt,      w_cnt_d;
    logic [1:0]    r_bu,       w_bu_d;
    logic          r_done,     w_done_d;
    logic          r_drop,     w_drop_d;

    logic [1:0]    w_step_nxt;
    logic [1:0]    w_code_nxt;
    logic [CW-1:0] w_dur_nxt;
    logic          w_last;

    // Tone code of a step; 00 marks a silent gap step.
    function automatic logic [1:0] f_code(input logic [1:0] t, input logic [1:0] s);
        logic [1:0] c;
        unique case (t)
            TypeClick:  c = 2'b01;
            TypeDouble: c = (s == 2'd1) ? 2'b00 : 2'b01;
            TypeAlarm:  c = (s == 2'd0) ? 2'b10 : 2'b00;
            TypeMelody: c = (s == 2'd0) ? 2'b10 : (s == 2'd1) ? 2'b01 :
                            (s == 2'd2) ? 2'b11 : 2'b00;
            default:    c = 2'b00;
        endcase
        return c;
    endfunction

    // Duration of a step in Tick pulses.
    function automatic logic [CW-1:0] f_dur(input logic [1:0] t, input logic [1:0] s);
        logic [CW-1:0] d;
        unique case (t)
            TypeClick:  d = LpShort;
            TypeDouble: d = (s == 2'd1) ? LpGap : LpShort;
            TypeAlarm:  d = (s == 2'd0) ? LpLong : LpGap;
            TypeMelody: d = LpNote;
            default:    d = LpOne;
        endcase
        return d;
    endfunction

    // True when the step is the final one of its pattern.
    function automatic logic f_last(input logic [1:0] t, input logic [1:0] s);
        logic l;
        unique case (t)
            TypeClick:  l = 1'b1;
            TypeDouble: l = (s == 2'd2);
`ifdef ALARM_REPEAT_EN
            TypeAlarm:  l = 1'b0;
`else
            TypeAlarm:  l = 1'b1;
`endif
            TypeMelody: l = (s == 2'd2);
            default:    l = 1'b1;
        endcase
        return l;
    endfunction

    // Step successor; the repeating alarm wraps from its gap back to the tone.
    assign w_step_nxt = (r_cur_type == TypeAlarm && r_step == 2'd1) ? 2'd0 : r_step + 2'd1;
    assign w_code_nxt = f_code(r_cur_type, w_step_nxt);
    assign w_dur_nxt  = f_dur(r_cur_type, w_step_nxt);
    assign w_last     = f_last(r_cur_type, r_step);

    // State and datapath registers; reset silences the buzzer asynchronously.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state    <= StIdle;
            r_cur_type <= 2'b00;
            r_step     <= 2'd0;
            r_cnt      <= '0;
            r_bu       <= 2'b00;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cur_type <= w_cur_type_d;
            r_step     <= w_step_d;
            r_cnt      <= w_cnt_d;
            r_bu       <= w_bu_d;
            r_done     <= w_done_d;
            r_drop     <= w_drop_d;
        end
    end

    // Next state: tick advance first, then request handling overrides it, then Ack overrides all.
    always_comb begin
        w_state_d    = r_state;
        w_cur_type_d = r_cur_type;
        w_step_d     = r_step;
        w_cnt_d      = r_cnt;
        w_bu_d       = r_bu;
        w_done_d     = 1'b0;
        w_drop_d     = 1'b0;

        if (r_state != StIdle && Tick) begin
            if (r_cnt == LpOne) begin
                if (w_last) begin
                    w_state_d = StIdle;
                    w_step_d  = 2'd0;
                    w_cnt_d   = '0;
                    w_bu_d    = 2'b00;
                    w_done_d  = 1'b1;
                end else begin
                    w_step_d  = w_step_nxt;
                    w_cnt_d   = w_dur_nxt;
                    w_bu_d    = w_code_nxt;
                    w_state_d = (w_code_nxt == 2'b00) ? StGap : StTone;
                end
            end else begin
                w_cnt_d = r_cnt - LpOne;
            end
        end

        if (Req) begin
            if (r_state == StIdle || ReqType >= r_cur_type) begin
                // Restart from step 0; a preempted pattern never reports Done.
                w_state_d    = StTone;
                w_cur_type_d = ReqType;
                w_step_d     = 2'd0;
                w_cnt_d      = f_dur(ReqType, 2'd0);
                w_bu_d       = f_code(ReqType, 2'd0);
                w_done_d     = 1'b0;
            end else begin
                // Rejected request leaves the running pattern (and its tick count) alone.
                w_drop_d = 1'b1;
            end
        end

        if (Ack) begin
            w_state_d = StIdle;
            w_step_d  = 2'd0;
            w_cnt_d   = '0;
            w_bu_d    = 2'b00;
            w_done_d  = 1'b0;
            w_drop_d  = 1'b0;
        end
    end

    assign Bu   = r_bu;
    assign Busy = (r_state != StIdle);
    assign Done = r_done;
    assign Drop = r_drop;

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed bench for buzzer_sequencer with short durations and Tick held high.
// Honours ALARM_REPEAT_EN to select the matching alarm expectations.
module tb_buzzer_sequencer;

    logic       Clk;
    logic       Rst;
    logic       Tick;
    logic       Req;
    logic [1:0] ReqType;
    logic       Ack;
    logic [1:0] Bu;
    logic       Busy;
    logic       Done;
    logic       Drop;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [1:0] exp_q[$];

    buzzer_sequencer #(
        .SHORT_T(3),
        .GAP_T  (2),
        .LONG_T (5),
        .NOTE_T (2),
        .CW     (10)
    ) u_dut (
        .Clk    (Clk),
        .Rst    (Rst),
        .Tick   (Tick),
        .Req    (Req),
        .ReqType(ReqType),
        .Ack    (Ack),
        .Bu     (Bu),
        .Busy   (Busy),
        .Done   (Done),
        .Drop   (Drop)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Checks Bu per cycle from exp_q (current cycle first); last entry is the Done cycle.
    task automatic run_seq(input string tag);
        int n;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0) cyc();
            chk2($sformatf("%s[%0d].bu", tag, i), Bu, exp_q[i]);
            chk1($sformatf("%s[%0d].done", tag, i), Done, (i == n - 1));
            chk1($sformatf("%s[%0d].busy", tag, i), Busy, (i != n - 1));
        end
        cyc();
        chk1({tag, ".done_end"}, Done, 1'b0);
        chk2({tag, ".bu_end"}, Bu, 2'b00);
    endtask

    initial begin
        Rst = 1'b1; Tick = 1'b1; Req = 1'b0; ReqType = 2'b00; Ack = 1'b0;
        #12;
        chk2("reset.bu", Bu, 2'b00);
        chk1("reset.busy", Busy, 1'b0);
        chk1("reset.done", Done, 1'b0);
        chk1("reset.drop", Drop, 1'b0);
        Rst = 1'b0;
        cyc();
        chk1("idle.busy", Busy, 1'b0);

        // Click
        Req = 1'b1; ReqType = 2'b00; cyc(); Req = 1'b0;
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b00};
        run_seq("click");

        // Equal-priority request restarts the click from step 0
        Req = 1'b1; ReqType = 2'b00; cyc(); Req = 1'b0;
        cyc();
        Req = 1'b1; ReqType = 2'b00; cyc(); Req = 1'b0;
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b00};
        run_seq("click_restart");

        // Double
        Req = 1'b1; ReqType = 2'b01; cyc(); Req = 1'b0;
        exp_q = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
        run_seq("double");

        // Melody
        Req = 1'b1; ReqType = 2'b11; cyc(); Req = 1'b0;
        exp_q = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
        run_seq("melody");

        // Preemption of click by melody, then a dropped click
        Req = 1'b1; ReqType = 2'b00; cyc(); Req = 1'b0;
        chk2("preempt.click_bu", Bu, 2'b01);
        Req = 1'b1; ReqType = 2'b11; cyc(); Req = 1'b0;
        chk2("preempt.mel1_bu", Bu, 2'b10);
        chk1("preempt.mel1_done", Done, 1'b0);
        Req = 1'b1; ReqType = 2'b00; cyc(); Req = 1'b0;
        chk2("preempt.mel2_bu", Bu, 2'b10);
        chk1("preempt.drop", Drop, 1'b1);
        chk1("preempt.mel2_busy", Busy, 1'b1);
        cyc();
        chk2("preempt.mel3_bu", Bu, 2'b01);
        chk1("preempt.drop_end", Drop, 1'b0);
        cyc();
        exp_q = '{2'b01, 2'b11, 2'b11, 2'b00};
        run_seq("preempt.tail");

        // Ack aborts an alarm
        Req = 1'b1; ReqType = 2'b10; cyc(); Req = 1'b0;
        chk2("abort.c1_bu", Bu, 2'b10);
        cyc();
        chk2("abort.c2_bu", Bu, 2'b10);
        Ack = 1'b1; cyc(); Ack = 1'b0;
        chk2("abort.bu", Bu, 2'b00);
        chk1("abort.busy", Busy, 1'b0);
        chk1("abort.done", Done, 1'b0);
        chk1("abort.drop", Drop, 1'b0);
        cyc();
        chk1("abort.done_late", Done, 1'b0);

        // Req and Ack together from idle
        Req = 1'b1; ReqType = 2'b10; Ack = 1'b1; cyc(); Req = 1'b0; Ack = 1'b0;
        chk1("reqack_idle.busy", Busy, 1'b0);
        chk2("reqack_idle.bu", Bu, 2'b00);
        chk1("reqack_idle.drop", Drop, 1'b0);

        // Low-priority Req with Ack while busy: no Drop
        Req = 1'b1; ReqType = 2'b11; cyc(); Req = 1'b0;
        Req = 1'b1; ReqType = 2'b00; Ack = 1'b1; cyc(); Req = 1'b0; Ack = 1'b0;
        chk1("reqack_busy.drop", Drop, 1'b0);
        chk1("reqack_busy.busy", Busy, 1'b0);

        // Asynchronous reset mid-tone
        Req = 1'b1; ReqType = 2'b10; cyc(); Req = 1'b0;
        cyc();
        chk2("rst.pre_bu", Bu, 2'b10);
        #3 Rst = 1'b1;
        #1;
        chk2("rst.async_bu", Bu, 2'b00);
        chk1("rst.async_busy", Busy, 1'b0);
        #1 Rst = 1'b0;
        cyc();
        chk1("rst.after_busy", Busy, 1'b0);

        // Alarm
        Req = 1'b1; ReqType = 2'b10; cyc(); Req = 1'b0;
`ifdef ALARM_REPEAT_EN
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 7; i++) begin
                chk2($sformatf("alarm_rep[%0d][%0d].bu", p, i), Bu,
                     (i < 5) ? 2'b10 : 2'b00);
                chk1($sformatf("alarm_rep[%0d][%0d].done", p, i), Done, 1'b0);
                chk1($sformatf("alarm_rep[%0d][%0d].busy", p, i), Busy, 1'b1);
                cyc();
            end
        end
        chk2("alarm_rep.p4_bu", Bu, 2'b10);
        Ack = 1'b1; cyc(); Ack = 1'b0;
        chk2("alarm_rep.ack_bu", Bu, 2'b00);
        chk1("alarm_rep.ack_busy", Busy, 1'b0);
        chk1("alarm_rep.ack_done", Done, 1'b0);
`else
        exp_q = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        run_seq("alarm");
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Timed beep-pattern generator. It turns one-cycle event requests from the workout FSM (key click, set complete, alarm, session finished) into a sequence of tone codes. It sits between the FSM and the top-level buzzer tone mux, and drives the 2-bit `Bu` code that selects silence, 1 kHz, 500 Hz or 2 kHz.

## Interface
Parameters:
- `SHORT_T`, default 100: length of a short beep, in `Tick` pulses.
- `GAP_T`, default 100: silence between beeps, in `Tick` pulses.
- `LONG_T`, default 1000: length of the alarm tone, in `Tick` pulses.
- `NOTE_T`, default 200: length of each melody note, in `Tick` pulses.
- `CW`, default 10: width of the duration counter. Every duration parameter must be ≥1 and ≤2^CW−1.

Ports (one clock; reset is asynchronous and active-high):
- `Clk`  in  1  system clock (FSM clock domain).
- `Rst`  in  1  async active-high reset.
- `Tick`  in  1  one-cycle timebase strobe, nominally 1 ms.
- `Req`  in  1  one-cycle request pulse.
- `ReqType`  in  2  pattern select: 00 click, 01 double, 10 alarm, 11 melody.
- `Ack`  in  1  one-cycle abort/acknowledge pulse.
- `Bu`  out  2  tone code: 00 silent, 01 1 kHz, 10 500 Hz, 11 2 kHz. Registered.
- `Busy`  out  1  high while a pattern is active.
- `Done`  out  1  one-cycle pulse on natural completion of a pattern.
- `Drop`  out  1  one-cycle pulse when a request is rejected.

## Operation
- States: IDLE, TONE, GAP. Internal registers:
  - `CurType` (2 bits)
  - `Step` (2 bits)
  - `Cnt` (CW bits)
- Patterns, as (code, duration) steps:
  - click: (01, SHORT_T).
  - double: (01, SHORT_T), gap GAP_T, (01, SHORT_T).
  - alarm: (10, LONG_T).
  - melody: (10, NOTE_T), (01, NOTE_T), (11, NOTE_T) back to back, with no gap.
- Accepting a request:
  - Load `CurType`, set `Step`=0, load `Cnt` with the first duration, enter TONE.
  - `Bu` takes the step-0 code.
- TONE/GAP: on each `Tick`, `Cnt` decrements. When a `Tick` arrives with `Cnt`==1, the step ends:
  - Next step is a tone: reload `Cnt`, stay or move to TONE, update `Bu`.
  - Next step is a gap: go to GAP with `Bu`=00.
  - Last step: go to IDLE with `Bu`=00 and pulse `Done`.
- Priority (numeric `ReqType`, higher wins):
  - `Req` while busy with `ReqType` ≥ `CurType`: restart with the new pattern from step 0. No `Done` is issued for the preempted pattern.
  - `Req` while busy with `ReqType` < `CurType`: ignore the request and pulse `Drop`.
- `Ack` in any state: go to IDLE with `Bu`=00. No `Done`, no `Drop`.
- `Req` and `Ack` in the same cycle: `Ack` wins and `Req` is discarded silently (no `Drop`).
- `Req` coinciding with a step-ending `Tick`: the request is evaluated against the current `CurType`, and request handling takes precedence over the step advance.
- Requests arriving in IDLE are always accepted.

## Timing
- Reset values:
  - `Bu`=00, `Busy`=0, `Done`=0, `Drop`=0.
  - State IDLE, `Cnt`=0, `Step`=0, `CurType`=00.
- Reset asserted mid-pattern silences `Bu` immediately, asynchronously.
- Latency:
  - `Req` sampled at edge k → `Bu`/`Busy` valid after edge k.
  - `Drop` is high during the cycle after edge k.
- Step duration is exactly N `Tick` pulses. A `Tick` in the same cycle as the `Req` that starts the step is not counted; the first counted `Tick` is in a later cycle.
- `Done` goes high in the cycle `Bu` returns to 00, after the final counted `Tick`.
- `Busy` falls in that same cycle.
- `Tick` held high continuously counts one per clock. This is a legal, test-only mode.

## Configuration
- `ALARM_REPEAT_EN`:
  - Defined: the alarm does not finish. After LONG_T it inserts a GAP_T silence, then replays (10, LONG_T), repeating indefinitely. Only `Ack`, `Rst` or a melody request (higher priority) ends it, so alarm never pulses `Done`.
  - Undefined: the alarm plays once and pulses `Done`.
- All other patterns are identical in both builds.

## Test plan
Bench parameters: SHORT_T=3, GAP_T=2, LONG_T=5, NOTE_T=2, `Tick` high every cycle.
- Click: `Req`, type 00 → `Bu`=01 for 3 cycles, then 00. `Done` pulses once. `Busy` is high for exactly 3 cycles.
- Double: type 01 → `Bu` sequence 01,01,01,00,00,01,01,01,00, then `Done`.
- Melody: type 11 → `Bu` sequence 10,10,01,01,11,11,00, then `Done`.
- Preemption:
  - Click in progress, then `Req` type 11 → melody restarts from step 0, with no `Done` for the click.
  - Then `Req` type 00 during the melody → `Drop` pulses once and the melody is unaffected.
- Abort, alarm started:
  - `Ack` at its 2nd cycle → `Bu`=00 next cycle, with no `Done`.
  - `Req` and `Ack` in the same cycle → stays idle, with no `Drop`.
  - `Rst` asserted mid-tone → `Bu`=00 asynchronously.
- `ALARM_REPEAT_EN` defined: alarm → 5×10, 2×00, 5×10, … for at least 3 periods, with no `Done`. `Ack` ends it. Undefined: a single 5×10 followed by `Done`.
